// File: rtl/adc_frame_aligner_if.sv
// adc_frame_aligner_if
// Groups the frame-alignment signals shared by the aligner and whatever drives it.
//   adc_en       enable level from the MicroBlaze GPIO; it is not synchronous to adc_clk
//   frmData      deserialised frame-clock word, one new value per adc_clk
//   bitslip      one-cycle pulse to every ISERDES bitslip input
//   aligned      high while the frame is locked
//   align_fail   high after the slip budget is exhausted
//   slip_count   bitslips issued in the current alignment attempt
//   relock_count lock losses since reset (saturating)
// The aligner connects through the slave modport and its driver through master.
interface adc_frame_aligner_if;
    logic       adc_en;
    logic [7:0] frmData;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic [7:0] slip_count;
    logic [7:0] relock_count;

    modport master (
        output adc_en,
        output frmData,
        input  bitslip,
        input  aligned,
        input  align_fail,
        input  slip_count,
        input  relock_count
    );

    modport slave (
        input  adc_en,
        input  frmData,
        output bitslip,
        output aligned,
        output align_fail,
        output slip_count,
        output relock_count
    );
endinterface

// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner
// Steps the ISERDES bitslip until the deserialised frame-clock word equals
// FRAME_PATTERN, reports lock, and keeps watching so that a sustained loss of
// the pattern starts a fresh alignment attempt.
// Ports:
//   adc_clk  divided ADC clock, the only clock
//   rst_adc  asynchronous active-high reset
//   fa       adc_frame_aligner_if slave: adc_en/frmData in; bitslip, aligned,
//            align_fail, slip_count and relock_count out (all registered)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | disabled; status flags clear, counters hold
// S_ALIGN  | count consecutive pattern matches; any miss asks for a slip
// S_SLIP   | single bitslip pulse
// S_SETTLE | ignore compare results while the ISERDES output catches up
// S_LOCKED | aligned; count consecutive misses toward re-alignment
// S_FAIL   | slip budget exhausted; waits for enable to drop
module adc_frame_aligner #(
    parameter logic [7:0] FRAME_PATTERN = 8'h0F,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MAX_SLIPS     = 16,
    parameter int         MISS_LIMIT    = 4
) (
    input logic           adc_clk,
    input logic           rst_adc,
    adc_frame_aligner_if.slave fa
);

    if (MATCH_COUNT < 2 || MATCH_COUNT > 255) begin : g_bad_match_count
        $error("adc_frame_aligner: MATCH_COUNT must be 2..255");
    end
    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle_cycles
        $error("adc_frame_aligner: SETTLE_CYCLES must be 2..255");
    end
    if (MAX_SLIPS < 1 || MAX_SLIPS > 255) begin : g_bad_max_slips
        $error("adc_frame_aligner: MAX_SLIPS must be 1..255");
    end
    if (MISS_LIMIT < 1 || MISS_LIMIT > 255) begin : g_bad_miss_limit
        $error("adc_frame_aligner: MISS_LIMIT must be 1..255");
    end

    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] MISS_LAST   = 8'(MISS_LIMIT - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SLIP_MAX    = 8'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_SLIP,
        S_SETTLE,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t     state_q, state_d;
    logic       en_meta_q, en_meta_d;
    logic       en_s_q, en_s_d;
    logic       match_q, match_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [7:0] slip_count_q, slip_count_d;
    logic [7:0] relock_count_q, relock_count_d;
    logic       bitslip_q, bitslip_d;
    logic       aligned_q, aligned_d;
    logic       align_fail_q, align_fail_d;

    always_comb begin
        en_meta_d = fa.adc_en;
        en_s_d    = en_meta_q;
        match_d   = (fa.frmData == FRAME_PATTERN);
    end

    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        slip_count_d   = slip_count_q;
        relock_count_d = relock_count_q;

        if (!en_s_q) begin
            // Disable wins over everything, but a pulse already on the wire
            // was really issued, so it is still counted.
            state_d = S_IDLE;
            if (state_q == S_SLIP) begin
                slip_count_d = slip_count_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_ALIGN;
                    slip_count_d = 8'd0;
                    run_cnt_d    = 8'd0;
                end
                S_ALIGN: begin
                    if (match_q) begin
                        if (run_cnt_q == MATCH_LAST) begin
                            state_d   = S_LOCKED;
                            run_cnt_d = 8'd0;
                        end else begin
                            run_cnt_d = run_cnt_q + 8'd1;
                        end
                    end else begin
                        run_cnt_d = 8'd0;
                        // The slip that would exceed the budget is never issued.
                        if (slip_count_q >= SLIP_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_SLIP;
                        end
                    end
                end
                S_SLIP: begin
                    state_d      = S_SETTLE;
                    slip_count_d = slip_count_q + 8'd1;
                    settle_cnt_d = SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        state_d   = S_ALIGN;
                        run_cnt_d = 8'd0;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                S_LOCKED: begin
                    if (match_q) begin
                        run_cnt_d = 8'd0;
                    end else if (run_cnt_q == MISS_LAST) begin
                        state_d      = S_ALIGN;
                        run_cnt_d    = 8'd0;
                        slip_count_d = 8'd0;
                        if (relock_count_q != 8'hFF) begin
                            relock_count_d = relock_count_q + 8'd1;
                        end
                    end else begin
                        run_cnt_d = run_cnt_q + 8'd1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Flags are registered from the next state so they line up with it.
        bitslip_d    = (state_d == S_SLIP);
        aligned_d    = (state_d == S_LOCKED);
        align_fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge adc_clk or posedge rst_adc) begin
        if (rst_adc) begin
            state_q        <= S_IDLE;
            en_meta_q      <= 1'b0;
            en_s_q         <= 1'b0;
            match_q        <= 1'b0;
            run_cnt_q      <= 8'd0;
            settle_cnt_q   <= 8'd0;
            slip_count_q   <= 8'd0;
            relock_count_q <= 8'd0;
            bitslip_q      <= 1'b0;
            aligned_q      <= 1'b0;
            align_fail_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            en_meta_q      <= en_meta_d;
            en_s_q         <= en_s_d;
            match_q        <= match_d;
            run_cnt_q      <= run_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            slip_count_q   <= slip_count_d;
            relock_count_q <= relock_count_d;
            bitslip_q      <= bitslip_d;
            aligned_q      <= aligned_d;
            align_fail_q   <= align_fail_d;
        end
    end

    assign fa.bitslip      = bitslip_q;
    assign fa.aligned      = aligned_q;
    assign fa.align_fail   = align_fail_q;
    assign fa.slip_count   = slip_count_q;
    assign fa.relock_count = relock_count_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb_adc_frame_aligner
// Directed bench for adc_frame_aligner. Stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them, and
// independently polices bitslip pulse width and spacing.
module tb_adc_frame_aligner;

    localparam int MC = 16;
    localparam int SC = 4;
    localparam int MS = 16;
    localparam int ML = 4;

    logic adc_clk = 1'b0;
    logic rst_adc;

    adc_frame_aligner_if ifc ();

    adc_frame_aligner #(
        .FRAME_PATTERN (8'h0F),
        .MATCH_COUNT   (MC),
        .SETTLE_CYCLES (SC),
        .MAX_SLIPS     (MS),
        .MISS_LIMIT    (ML)
    ) dut (
        .adc_clk (adc_clk),
        .rst_adc (rst_adc),
        .fa      (ifc)
    );

    always #5 adc_clk = ~adc_clk;

    // ---------------- frame source model ----------------
    // In rotating mode the word is the pattern rotated by the slips still
    // needed; every observed bitslip pulse removes one rotation.
    logic       use_rot;
    logic       bad_en;
    logic [7:0] const_word;
    int         rot_start;
    int         rot_base;
    int         pulse_cnt = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        return (v << n) | (v >> (4'd8 - {1'b0, n}));
    endfunction

    always_comb begin
        logic [2:0] r;
        r = 3'(rot_start - (pulse_cnt - rot_base));
        if (bad_en)       ifc.frmData = 8'hA5;
        else if (use_rot) ifc.frmData = rotl8(8'h0F, r);
        else              ifc.frmData = const_word;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string      name;
        int         kind;      // 0 status, 1 range, 2 timeout
        logic       al;
        logic       fl;
        logic       bs;
        logic [7:0] sc;
        logic [7:0] rc;
        int         pulses;    // -1: not checked
        int         base;
        int         act;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_pulse  = -100;
    logic prev_bs     = 1'b0;

    always @(negedge adc_clk) begin
        exp_t e;
        cyc++;
        if (rst_adc) begin
            last_pulse = -100;
            prev_bs    = 1'b0;
        end else if (ifc.bitslip === 1'b1) begin
            pulse_cnt++;
            vectors++;
            if (prev_bs || (cyc - last_pulse) < SC + 2) begin
                miscompares++;
                $display("FAIL pulse_spacing: gap %0d cycles back_to_back=%0b, required gap >= %0d",
                         cyc - last_pulse, prev_bs, SC + 2);
            end
            last_pulse = cyc;
            prev_bs    = 1'b1;
        end else begin
            prev_bs = 1'b0;
        end

        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            case (e.kind)
                0: begin
                    if (ifc.aligned !== e.al || ifc.align_fail !== e.fl ||
                        ifc.bitslip !== e.bs || ifc.slip_count !== e.sc ||
                        ifc.relock_count !== e.rc ||
                        (e.pulses >= 0 && (pulse_cnt - e.base) != e.pulses)) begin
                        miscompares++;
                        $display("FAIL %s: got aligned=%b fail=%b bitslip=%b slip=%0d relock=%0d pulses=%0d; want aligned=%b fail=%b bitslip=%b slip=%0d relock=%0d pulses=%0d",
                                 e.name, ifc.aligned, ifc.align_fail, ifc.bitslip,
                                 ifc.slip_count, ifc.relock_count, pulse_cnt - e.base,
                                 e.al, e.fl, e.bs, e.sc, e.rc, e.pulses);
                    end
                end
                1: begin
                    if (e.act < e.lo || e.act > e.hi) begin
                        miscompares++;
                        $display("FAIL %s: got %0d, want %0d..%0d", e.name, e.act, e.lo, e.hi);
                    end
                end
                default: begin
                    miscompares++;
                    $display("FAIL %s: event not seen within %0d cycles", e.name, e.act);
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic expect_st(input string nm, input logic al, input logic fl,
                             input logic [7:0] sc, input logic [7:0] rc,
                             input logic bs, input int pulses, input int base);
        exp_t e;
        e.name = nm; e.kind = 0;
        e.al = al; e.fl = fl; e.bs = bs; e.sc = sc; e.rc = rc;
        e.pulses = pulses; e.base = base;
        e.act = 0; e.lo = 0; e.hi = 0;
        sb.push_back(e);
    endtask

    task automatic expect_rng(input string nm, input int act, input int lo, input int hi);
        exp_t e;
        e.name = nm; e.kind = 1;
        e.al = 1'b0; e.fl = 1'b0; e.bs = 1'b0; e.sc = 8'd0; e.rc = 8'd0;
        e.pulses = -1; e.base = 0;
        e.act = act; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // which: 0 aligned, 1 align_fail, 2 bitslip
    task automatic wait_for(input int which, input int max, input string nm, output int n);
        logic hit;
        exp_t e;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < max) begin
            tick(1);
            n++;
            case (which)
                0:       hit = (ifc.aligned === 1'b1);
                1:       hit = (ifc.align_fail === 1'b1);
                default: hit = (ifc.bitslip === 1'b1);
            endcase
        end
        if (!hit) begin
            e.name = nm; e.kind = 2;
            e.al = 1'b0; e.fl = 1'b0; e.bs = 1'b0; e.sc = 8'd0; e.rc = 8'd0;
            e.pulses = -1; e.base = 0;
            e.act = max; e.lo = 0; e.hi = 0;
            sb.push_back(e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int base;
        rst_adc    = 1'b1;
        ifc.adc_en = 1'b0;
        use_rot    = 1'b0;
        bad_en     = 1'b0;
        const_word = 8'h0F;
        rot_start  = 0;
        rot_base   = 0;

        tick(3);
        expect_st("reset", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0, 0);
        rst_adc = 1'b0;
        tick(2);
        expect_st("idle_disabled", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0, 0);

        // Already aligned: 2 sync + 1 enter ALIGN + MC matches.
        base       = pulse_cnt;
        ifc.adc_en = 1'b1;
        wait_for(0, 40, "t1_wait_lock", n);
        expect_rng("t1_lock_latency", n, MC + 3, MC + 4);
        expect_st("t1_locked", 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 0, base);
        tick(10);
        expect_st("t1_hold", 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 0, base);
        ifc.adc_en = 1'b0;
        tick(3);
        expect_st("t1_off", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0, base);

        // Three rotations off.
        rot_base   = pulse_cnt;
        rot_start  = 3;
        use_rot    = 1'b1;
        base       = pulse_cnt;
        ifc.adc_en = 1'b1;
        wait_for(0, 200, "t2_wait_lock", n);
        expect_st("t2_locked", 1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 3, base);

        // Loss below and at MISS_LIMIT.
        tick(2);
        bad_en = 1'b1;
        tick(ML - 1);
        bad_en = 1'b0;
        tick(3);
        expect_st("t4_three_bad", 1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 3, base);
        tick(2);
        bad_en = 1'b1;
        tick(ML);
        bad_en = 1'b0;
        tick(2);
        expect_st("t4_four_bad", 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 3, base);
        wait_for(0, 40, "t4_wait_relock", n);
        expect_st("t4_relocked", 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 3, base);
        ifc.adc_en = 1'b0;
        tick(3);
        expect_st("t4_off", 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 3, base);

        // Pattern never found.
        use_rot    = 1'b0;
        const_word = 8'h55;
        base       = pulse_cnt;
        ifc.adc_en = 1'b1;
        wait_for(1, 300, "t3_wait_fail", n);
        expect_st("t3_fail", 1'b0, 1'b1, 8'(MS), 8'd1, 1'b0, MS, base);
        tick(20);
        expect_st("t3_quiet", 1'b0, 1'b1, 8'(MS), 8'd1, 1'b0, MS, base);
        ifc.adc_en = 1'b0;
        tick(3);
        expect_st("t3_off", 1'b0, 1'b0, 8'(MS), 8'd1, 1'b0, MS, base);
        ifc.adc_en = 1'b1;
        tick(3);
        expect_st("t3_restart", 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, MS, base);

        // Drop enable mid-ALIGN: the slip already decided completes, then IDLE.
        ifc.adc_en = 1'b0;
        tick(20);
        expect_st("t6_drop", 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, MS + 1, base);

        // Reset during SLIP.
        base       = pulse_cnt;
        ifc.adc_en = 1'b1;
        wait_for(2, 20, "t5_wait_slip", n);
        rst_adc    = 1'b1;
        ifc.adc_en = 1'b0;
        expect_st("t5_rst_in_slip", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, -1, base);
        tick(2);
        rst_adc = 1'b0;
        tick(5);
        expect_st("t5_idle_after_slip", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, -1, base);

        // Reset during SETTLE.
        ifc.adc_en = 1'b1;
        wait_for(2, 20, "t5_wait_slip2", n);
        tick(1);
        expect_st("t5_in_settle", 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, -1, base);
        tick(1);
        rst_adc    = 1'b1;
        ifc.adc_en = 1'b0;
        expect_st("t5_rst_in_settle", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, -1, base);
        tick(2);
        rst_adc = 1'b0;
        base    = pulse_cnt;
        tick(10);
        expect_st("t5_idle_after_settle", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0, base);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got time %0t, want completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
